// File: rtl/any1_pkg.sv
// any1_pkg: shared enums for the ANY-1 vector address generator
package any1_pkg;
  typedef enum logic [1:0] {AGM_UNIT = 2'd0, AGM_STRIDE = 2'd1, AGM_INDEX = 2'd2} agen_mode_t;
  typedef enum logic [1:0] {VAG_IDLE = 2'd0, VAG_RUN = 2'd1, VAG_FIN = 2'd2} vagen_state_t;
endpackage

// File: rtl/any1_ffs.sv
// any1_ffs: find-first-set, lowest set bit index plus found flag
module any1_ffs #(
  parameter int W  = 16,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  v,
  output logic [IW-1:0] idx,
  output logic          found
);
  // scan from the top so the lowest set bit is the final assignment
  always_comb begin
    idx = '0;
    found = |v;
    for (int i = W - 1; i >= 0; i--) if (v[i]) idx = IW'(i);
  end
endmodule

// File: rtl/any1_vagen.sv
// any1_vagen: vector address generator, one effective address per active element
module any1_vagen
  import any1_pkg::*;
#(
  parameter int AWID = 32,
  parameter int VLEN = 16,
  parameter int EWID = $clog2(VLEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_mode,
  input  logic [1:0]           req_sz,
  input  logic [2:0]           req_sc,
  input  logic [AWID-1:0]      req_base,
  input  logic [AWID-1:0]      req_imm,
  input  logic [AWID-1:0]      req_stride,
  input  logic [EWID:0]        req_vl,
  input  logic [VLEN-1:0]      req_mask,
  input  logic [VLEN*AWID-1:0] req_idx,
  output logic                 ea_valid,
  input  logic                 ea_ready,
  output logic [AWID-1:0]      ea,
  output logic [EWID-1:0]      ea_elem,
  output logic                 ea_last,
  output logic                 busy,
  output logic                 done
);
  localparam int NW = EWID + 1;

  vagen_state_t state_q, state_d;
  logic [1:0] mode_q, mode_d, sz_q, sz_d;
  logic [2:0] sc_q, sc_d;
  logic [AWID-1:0] bi_q, bi_d, stride_q, stride_d, ea_q, ea_d;
  logic [NW-1:0] vl_q, vl_d;
  logic [VLEN-1:0] mask_q, mask_d;
  logic [VLEN*AWID-1:0] idx_q, idx_d;
  logic [EWID-1:0] ea_elem_q, ea_elem_d;
  logic ea_last_q, ea_last_d;

  logic idle, accept, adv, found, last;
  logic [NW-1:0] vl_c, s_vl, s_from;
  logic [VLEN-1:0] s_mask, src;
  logic [EWID-1:0] f;
  logic [AWID-1:0] s_bi, s_stride, addr;
  logic [1:0] s_mode, s_sz;
  logic [2:0] s_sc;
  logic [VLEN*AWID-1:0] s_idx;

  function automatic logic [VLEN-1:0] lane_ge(input logic [NW-1:0] k);
    logic [VLEN-1:0] r;
    for (int i = 0; i < VLEN; i++) r[i] = NW'(i) >= k;
    return r;
  endfunction

  function automatic logic [VLEN-1:0] lane_lt(input logic [NW-1:0] n);
    logic [VLEN-1:0] r;
    for (int i = 0; i < VLEN; i++) r[i] = NW'(i) < n;
    return r;
  endfunction

  function automatic logic [AWID-1:0] off_f(input logic [1:0] m, input logic [1:0] sz,
                                            input logic [2:0] sc, input logic [AWID-1:0] st,
                                            input logic [VLEN*AWID-1:0] ix, input logic [EWID-1:0] e);
    logic [AWID-1:0] ei;
    ei = AWID'(e);
    return m == AGM_STRIDE ? ei * st : m == AGM_INDEX ? ix[AWID*int'(e) +: AWID] << sc : ei << sz;
  endfunction

  any1_ffs #(.W(VLEN), .IW(EWID)) u_ffs (.v(src), .idx(f), .found(found));

  // pick the next active element: from the request while idle, past the current one while running
  always_comb begin
    idle = state_q == VAG_IDLE;
    accept = idle & req_valid & ~flush;
    adv = state_q == VAG_RUN & ea_ready & ~ea_last_q & ~flush;
    vl_c = req_vl > NW'(VLEN) ? NW'(VLEN) : req_vl;
    s_mask = idle ? req_mask : mask_q;
    s_vl = idle ? vl_c : vl_q;
    s_from = idle ? '0 : NW'(ea_elem_q) + NW'(1);
    src = s_mask & lane_ge(s_from) & lane_lt(s_vl);
    last = ~|(src & lane_ge(NW'(f) + NW'(1)));
    s_mode = idle ? req_mode : mode_q;
    s_sz = idle ? req_sz : sz_q;
    s_sc = idle ? req_sc : sc_q;
    s_bi = idle ? req_base + req_imm : bi_q;
    s_stride = idle ? req_stride : stride_q;
    s_idx = idle ? req_idx : idx_q;
    addr = s_bi + off_f(s_mode, s_sz, s_sc, s_stride, s_idx, f);
  end

  // latch the request on accept and load the next address on accept or advance
  always_comb begin
    mode_d = accept ? req_mode : mode_q;
    sz_d = accept ? req_sz : sz_q;
    sc_d = accept ? req_sc : sc_q;
    bi_d = accept ? req_base + req_imm : bi_q;
    stride_d = accept ? req_stride : stride_q;
    vl_d = accept ? vl_c : vl_q;
    mask_d = accept ? req_mask : mask_q;
    idx_d = accept ? req_idx : idx_q;
    ea_d = accept | adv ? addr : ea_q;
    ea_elem_d = accept | adv ? f : ea_elem_q;
    ea_last_d = accept | adv ? last : ea_last_q;
  end

  // next-state: flush always wins, empty requests go straight to FIN
  always_comb begin
    state_d = flush ? VAG_IDLE
            : idle ? (req_valid ? (found ? VAG_RUN : VAG_FIN) : VAG_IDLE)
            : state_q == VAG_RUN ? (ea_ready & ea_last_q ? VAG_FIN : VAG_RUN)
            : VAG_IDLE;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= VAG_IDLE;
    else state_q <= state_d;
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= '0;
      sz_q <= '0;
      sc_q <= '0;
      bi_q <= '0;
      stride_q <= '0;
      vl_q <= '0;
      mask_q <= '0;
      idx_q <= '0;
      ea_q <= '0;
      ea_elem_q <= '0;
      ea_last_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      sz_q <= sz_d;
      sc_q <= sc_d;
      bi_q <= bi_d;
      stride_q <= stride_d;
      vl_q <= vl_d;
      mask_q <= mask_d;
      idx_q <= idx_d;
      ea_q <= ea_d;
      ea_elem_q <= ea_elem_d;
      ea_last_q <= ea_last_d;
    end
  end

  // outputs decoded from registered state
  always_comb begin
    req_ready = rst & idle & ~flush;
    ea_valid = state_q == VAG_RUN;
    done = state_q == VAG_FIN;
    busy = state_q != VAG_IDLE;
    ea = ea_q;
    ea_elem = ea_elem_q;
    ea_last = ea_last_q;
  end
endmodule

// File: doc/any1_vagen.md
# any1_vagen

Parametrised vector address generator for the ANY-1 memory stage. It accepts one vector load/store request and issues one effective address per active element, in element order, over a valid/ready stream. Three address modes are supported: unit-stride, strided and indexed (gather/scatter). It sits between the vector issue logic and the load/store queue, replacing the single-address scalar generator for LDSx/STSx, LDxVX/STxVX and CVLDSx/CVSTSx.

## Interface
Parameters:
- AWID, 32: address width.
- VLEN, 16: maximum element count. Must be a power of two, at least 2.
- EWID, $clog2(VLEN): element index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- flush  in  1  abort any operation in progress
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_mode  in  2  agen_mode_t: 0 unit, 1 strided, 2 indexed, 3 reserved (treated as unit)
- req_sz  in  2  element size, log2 bytes (unit mode)
- req_sc  in  3  index scale shift (indexed mode)
- req_base  in  AWID  base register value
- req_imm  in  AWID  displacement
- req_stride  in  AWID  byte stride (strided mode)
- req_vl  in  EWID+1  vector length, 0..VLEN
- req_mask  in  VLEN  element enable mask; bit i enables element i
- req_idx  in  VLEN*AWID  index vector; element i is at [i*AWID +: AWID]
- ea_valid  out  1  address valid
- ea_ready  in  1  consumer accepts address
- ea  out  AWID  effective address
- ea_elem  out  EWID  element number of ea
- ea_last  out  1  ea is the final active element
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when a request completes

## Operation
- All request fields are latched on accept (req_valid & req_ready).
- Active set: elements i < vl with mask[i]=1.
- For element i, the address is base + imm + off(i), taken modulo 2^AWID:
  - unit: off(i) = i << sz.
  - strided: off(i) = i * stride, truncated to AWID.
  - indexed: off(i) = idx[i] << sc, truncated.
- Addresses are emitted in ascending i. Masked elements are skipped with zero cycle cost; the next active element is found by priority encode.
- States:
  - IDLE:
    - req_ready = ~flush.
    - On accept with an empty active set (vl=0 or no enabled bit below vl), go to FIN.
    - Otherwise go to RUN.
  - RUN:
    - ea_valid=1 with the current element.
    - On ea_ready, advance to the next active element.
    - If the current element is the last active one, go to FIN instead.
  - FIN: done=1 for one cycle, then go to IDLE.
- ea, ea_elem and ea_last hold stable while ea_valid & ~ea_ready.
- flush in any state: go to IDLE next cycle. ea_valid, done and busy are 0 from that cycle. No done is pulsed for an aborted request. A request presented on a flush cycle is not accepted.
- vl > VLEN is clamped to VLEN.
- Reset (rst=0) values: state IDLE, ea_valid 0, ea 0, ea_elem 0, ea_last 0, done 0, busy 0. req_ready is 1 from the first cycle after reset is released. Reset mid-operation discards the request.

## Timing
- Accept at cycle N: the first ea_valid is at N+1, registered. done is the cycle after the last handshake.
- Throughput is 1 address/cycle with ea_ready held high, independent of mask gaps.
- Accept with an empty active set at N: done at N+1, no ea_valid.
- Minimum request-to-request spacing is k+2 cycles for k active elements, because req_ready is 0 in RUN and FIN.
- All outputs are registered. Inputs to ea_valid have no combinational path from ea_ready, except the advance enable.

## Structure
- any1_pkg gains:
  - agen_mode_t enum (AGM_UNIT, AGM_STRIDE, AGM_INDEX).
  - vagen_state_t enum (VAG_IDLE, VAG_RUN, VAG_FIN).
- Sub-module any1_ffs #(W): find-first-set over a W-bit vector, outputs index and a found flag. It is used on mask & (lane_ge(cur+1)) & lane_lt(vl).
- The strided multiply may be EWID x AWID, combinational or pipelined. Pipelined is allowed only if the timing above is preserved.

## Test plan
- Unit mode: base=0x1000, imm=0x10, sz=2, vl=4, mask=0xF, ea_ready=1 -> ea 0x1010, 0x1014, 0x1018, 0x101C on consecutive cycles. ea_last on 0x101C, done the next cycle.
- Strided with mask gaps: base=0x2000, imm=0, stride=0x100, vl=8, mask=0b10100101 -> elements 0,2,5,7 at 0x2000, 0x2200, 0x2500, 0x2700, four back-to-back cycles.
- Indexed with back-pressure: sc=3, idx[0..2]=5,1,0xFFFFFFFF, base=0x40, vl=3, ea_ready toggling -> ea 0x68, 0x48, 0x38 (wrap). Each value is held until accepted.
- Empty requests: vl=0 -> done at N+1, no ea_valid. Repeat with vl=4, mask=0xF0 -> same result.
- Flush mid-RUN after 2 of 4 addresses, with req_valid asserted on the same cycle -> ea_valid=0 next cycle, no done, req not accepted. It is accepted on the following cycle.
- Reset: rst=0 during RUN -> all outputs zero next cycle. After release, req_ready=1 and a new request runs correctly.
